load_use_scoreboard: RTL and testbench
======================================

// Module: load_use_scoreboard
// PURPOSE
//   Producer-side hazard tracker for the 5-stage RV32I pipeline; the interlock counterpart of EX-stage forwarding.
//   Records destination regs of in-flight loads (issued into EX, not yet written back) in a pending mask.
//   Stalls ID and bubbles ID/EX while the ID instruction reads a pending reg; forwarding covers all other RAW cases.
//   Tolerates variable data-memory latency: a load's bit holds until its writeback strobe.
// PARAMETERS
//   NREG       32  architectural register count; bit i of pending mask = x[i]
//   MAX_STALL  15  consecutive stall cycles before sticky stall_err asserts (1..255)
// PORTS
//   clk           in   1   system clock, rising edge
//   rst           in   1   synchronous, active-high reset
//   id_inst       in   32  instruction currently in ID
//   id_valid      in   1   id_inst is a real instruction (0 = bubble)
//   ex_inst       in   32  instruction entering EX this cycle (I3 slot)
//   ex_valid      in   1   ex_inst is real; ignored while bubble=1
//   wb_rd         in   5   dest reg of load completing writeback
//   wb_load_done  in   1   load in WB writes wb_rd this cycle
//   stall         out  1   hold PC and IF/ID this cycle (combinational)
//   bubble        out  1   force NOP into ID/EX this cycle (= stall)
//   pending       out  NREG current pending mask (registered)
//   stall_err     out  1   sticky: stall exceeded MAX_STALL cycles
//   stall_cycles  out  32  total stall cycles (only with SCOREBOARD_STATS_EN)
// BEHAVIOUR
//   Reset (rst=1 at clk edge): pending=0, state=RUN, stall_cnt=0, stall_err=0, stall_cycles=0.
//     While rst=1, stall and bubble are forced to 0.
//   Source use, decoded from id_inst[6:0]:
//     rs1 used by every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111.
//     rs2 used only by OP 0110011, STORE 0100011, BRANCH 1100011.
//   Effective mask eff = pending & ~clr, where clr = wb_load_done ? onehot(wb_rd) : 0.
//     Same-cycle WB releases the reg; the regfile is write-first.
//   hazard = id_valid & ((use_rs1 & eff[rs1]) | (use_rs2 & eff[rs2])).
//     rs = 0 never hazards. stall = bubble = hazard (Mealy, zero latency).
//   Set: ex_valid & ~bubble & opcode==LOAD 0000011 & rd!=0 -> set pending[rd] next edge.
//   Set and clear on the same rd in the same cycle: set wins (a newer load takes the reg).
//   Clear of a non-pending reg is a no-op; wb_rd=0 is a no-op.
//   FSM, 2 states:
//     RUN   -> STALL when hazard; stall_cnt <= 1.
//     STALL -> RUN when !hazard; stall_cnt <= 0.
//     STALL -> STALL while hazard; stall_cnt saturates at 255.
//     stall_cnt == MAX_STALL while in STALL -> stall_err <= 1; cleared only by rst.
//   Reset mid-stall: next cycle state=RUN, pending empty, no stall even if id_inst still reads the old rd.
//   Back-to-back loads to different rd: both bits pending; each clears independently.
// CONFIGURATION
//   SCOREBOARD_STATS_EN defined:
//     stall_cycles is a 32-bit counter, +1 each cycle stall=1; wraps 0xFFFFFFFF -> 0.
//   SCOREBOARD_STATS_EN undefined:
//     stall_cycles tied to 0; no counter flops.
// STRUCTURE
//   Shared package rv32_pkg: opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL)
//     and field slices RD[11:7], RS1[19:15], RS2[24:20]; the forwarding unit uses the same package.
//   One sub-module: src_use_decode (opcode -> use_rs1, use_rs2), purely combinational, reused by forwarding.
//   FSM, stall counter and pending mask live in the top module.
// TESTING
//   1. lw x5 enters EX (ex_inst=0x0002A283); next cycle id_inst add x6,x5,x1 -> stall=1 one cycle,
//      then wb_load_done & wb_rd=5 -> stall=0 same cycle; pending[5]=0.
//   2. Load x0 (rd=0) issued; ID reads x0 -> pending stays 0, stall never asserts.
//   3. lw x7 pending; ID = lui x8 (rs1 field=7) -> no stall; ID = sw x7,0(x2) -> stall (rs2 use).
//   4. WB clears x9 while a new lw x9 enters EX in the same cycle -> pending[9]=1 afterwards.
//   5. Hold x10 pending, no WB for 16 cycles with a dependent ID -> stall_err=1 at cycle 15, still 1 after release.
//   6. rst=1 mid-stall -> next cycle stall=0, pending=0, stall_err=0; with SCOREBOARD_STATS_EN, stall_cycles=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode constants and instruction field helpers
// Shared by the load-use scoreboard and the EX-stage forwarding unit.
package rv32_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } sb_state_e;

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

endpackage

// File: rtl/src_use_decode.sv
// rtl/src_use_decode.sv - opcode to source-register-use decode
// Purely combinational; also instantiated by the forwarding unit.
module src_use_decode
    import rv32_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       use_rs1,
    output logic       use_rs2
);

    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        if (opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL) begin
            use_rs1 = 1'b0;
        end
        if (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH) begin
            use_rs2 = 1'b1;
        end
    end

endmodule

// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - load-use interlock: pending-load mask, ID stall, stall watchdog
// Optional SCOREBOARD_STATS_EN adds a free-running 32-bit stall cycle counter.
module load_use_scoreboard
    import rv32_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int MAX_STALL = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     id_inst,
    input  logic            id_valid,
    input  logic [31:0]     ex_inst,
    input  logic            ex_valid,
    input  logic [4:0]      wb_rd,
    input  logic            wb_load_done,
    output logic            stall,
    output logic            bubble,
    output logic [NREG-1:0] pending,
    output logic            stall_err,
    output logic [31:0]     stall_cycles
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    sb_state_e       state_q, state_d;
    logic [7:0]      stall_cnt_q, stall_cnt_d;
    logic            stall_err_q, stall_err_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            use_rs1, use_rs2;
    logic [4:0]      rs1, rs2, ex_rd;
    logic [NREG-1:0] clr, set, eff;
    logic            hazard;
    logic            unused_bits;

    assign unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:12]};

    src_use_decode u_decode (
        .opcode  (inst_opcode(id_inst)),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    always_comb begin
        rs1   = inst_rs1(id_inst);
        rs2   = inst_rs2(id_inst);
        ex_rd = inst_rd(ex_inst);
        clr   = (wb_load_done && wb_rd != 5'd0) ? (ONE << wb_rd) : '0;
        // Writeback in the same cycle releases the reg: the regfile is write-first.
        eff   = pending_q & ~clr;
        hazard = id_valid &&
                 ((use_rs1 && rs1 != 5'd0 && eff[rs1]) ||
                  (use_rs2 && rs2 != 5'd0 && eff[rs2]));
        stall  = hazard && !rst;
        bubble = stall;
        set = (ex_valid && !bubble && inst_opcode(ex_inst) == OPC_LOAD && ex_rd != 5'd0)
              ? (ONE << ex_rd) : '0;
        // A newer load to the same rd wins over the older one's writeback.
        pending_d = eff | set;
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d     = ST_STALL;
                    stall_cnt_d = 8'd1;
                end
            end
            ST_STALL: begin
                if (!stall) begin
                    state_d     = ST_RUN;
                    stall_cnt_d = 8'd0;
                end else if (stall_cnt_q != 8'hFF) begin
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
                if (stall_cnt_q == 8'(MAX_STALL)) begin
                    stall_err_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                stall_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 8'd0;
            stall_err_q <= 1'b0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
            pending_q   <= pending_d;
        end
    end

    assign pending   = pending_q;
    assign stall_err = stall_err_q;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb/tb_load_use_scoreboard.sv - table-driven self-checking bench for load_use_scoreboard
module tb_load_use_scoreboard;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
    localparam logic [6:0] OP = 7'b0110011, LUI = 7'b0110111, JAL = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_inst, ex_inst;
    logic        id_valid, ex_valid, wb_load_done;
    logic [4:0]  wb_rd;
    logic        stall, bubble, stall_err;
    logic [31:0] pending, stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] id_inst;
        logic        id_valid;
        logic [31:0] ex_inst;
        logic        ex_valid;
        logic [4:0]  wb_rd;
        logic        wb_done;
        logic        exp_stall;
        logic [31:0] exp_pend;
    } vec_t;

    typedef struct {
        logic        stall;
        logic [31:0] pend;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    always #5 clk = ~clk;

    load_use_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .ex_inst      (ex_inst),
        .ex_valid     (ex_valid),
        .wb_rd        (wb_rd),
        .wb_load_done (wb_load_done),
        .stall        (stall),
        .bubble       (bubble),
        .pending      (pending),
        .stall_err    (stall_err),
        .stall_cycles (stall_cycles)
    );

    function automatic logic [31:0] mk(input logic [6:0] opc, input int rd, input int rs1, input int rs2);
        logic [4:0] d, s1, s2;
        d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
        return {7'd0, s2, s1, 3'b010, d, opc};
    endfunction

    function automatic logic [31:0] bit_of(input int r);
        logic [31:0] one;
        one = 32'd1;
        return one << r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] idi, input logic idv, input logic [31:0] exi,
                           input logic exv, input int wrd, input logic wdone,
                           input logic es, input logic [31:0] ep);
        vec_t v;
        v.id_inst = idi; v.id_valid = idv; v.ex_inst = exi; v.ex_valid = exv;
        v.wb_rd = 5'(wrd); v.wb_done = wdone; v.exp_stall = es; v.exp_pend = ep;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] idi, input logic idv, input logic [31:0] exi,
                         input logic exv, input logic [4:0] wrd, input logic wdone);
        id_inst = idi; id_valid = idv; ex_inst = exi; ex_valid = exv;
        wb_rd = wrd; wb_load_done = wdone;
    endtask

    task automatic idle();
        drive(32'h0000_0013, 1'b0, 32'h0000_0013, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] nop;
        logic [31:0] dep10;
        exp_t e;
        logic stall_seen;
        nop = 32'h0000_0013;
        dep10 = mk(OP, 3, 10, 1);

        // One cycle per row: expected stall during the cycle, expected pending after the edge.
        add_vec(nop, 0, 32'h0002A283, 1, 0, 0, 0, bit_of(5));
        add_vec(32'h00128333, 1, nop, 0, 0, 0, 1, bit_of(5));
        add_vec(32'h00128333, 1, nop, 0, 5, 1, 0, 32'd0);
        add_vec(nop, 0, mk(LOAD, 0, 2, 0), 1, 0, 0, 0, 32'd0);
        add_vec(mk(OP, 1, 0, 0), 1, nop, 0, 0, 0, 0, 32'd0);
        add_vec(nop, 0, mk(LOAD, 7, 2, 0), 1, 0, 0, 0, bit_of(7));
        add_vec(mk(LUI, 8, 7, 0), 1, nop, 0, 0, 0, 0, bit_of(7));
        add_vec(mk(STORE, 0, 2, 7), 1, mk(LOAD, 11, 2, 0), 1, 0, 0, 1, bit_of(7));
        add_vec(mk(STORE, 0, 2, 7), 1, nop, 0, 7, 1, 0, 32'd0);
        add_vec(nop, 0, mk(LOAD, 9, 2, 0), 1, 0, 0, 0, bit_of(9));
        add_vec(nop, 0, mk(LOAD, 9, 3, 0), 1, 9, 1, 0, bit_of(9));
        add_vec(nop, 0, nop, 0, 9, 1, 0, 32'd0);
        add_vec(nop, 0, mk(LOAD, 12, 2, 0), 1, 0, 0, 0, bit_of(12));
        add_vec(nop, 0, mk(LOAD, 13, 2, 0), 1, 0, 0, 0, bit_of(12) | bit_of(13));
        add_vec(mk(OP, 1, 2, 13), 1, nop, 0, 12, 1, 1, bit_of(13));
        add_vec(mk(OP, 1, 2, 13), 1, nop, 0, 13, 1, 0, 32'd0);
        add_vec(nop, 0, nop, 0, 0, 1, 0, 32'd0);
        add_vec(nop, 0, mk(LOAD, 14, 2, 0), 1, 0, 0, 0, bit_of(14));
        add_vec(mk(OP, 1, 14, 0), 0, nop, 0, 0, 0, 0, bit_of(14));
        add_vec(nop, 0, nop, 0, 14, 1, 0, 32'd0);
        add_vec(nop, 0, mk(LOAD, 15, 2, 0), 1, 0, 0, 0, bit_of(15));
        add_vec(mk(JAL, 1, 15, 0), 1, nop, 0, 0, 0, 0, bit_of(15));
        add_vec(mk(BRANCH, 0, 2, 15), 1, nop, 0, 0, 0, 1, bit_of(15));
        add_vec(mk(BRANCH, 0, 2, 15), 1, nop, 0, 15, 1, 0, 32'd0);

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_pending", pending, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_err", {31'd0, stall_err}, 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].id_inst, vecs[i].id_valid, vecs[i].ex_inst, vecs[i].ex_valid,
                  vecs[i].wb_rd, vecs[i].wb_done);
            e.stall = vecs[i].exp_stall;
            e.pend  = vecs[i].exp_pend;
            sb_q.push_back(e);
            @(negedge clk);
            stall_seen = stall;
            check($sformatf("vec%0d_bubble", i), {31'd0, bubble}, {31'd0, stall_seen});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("vec%0d_stall", i), {31'd0, stall_seen}, {31'd0, e.stall});
            check($sformatf("vec%0d_pending", i), pending, e.pend);
        end
        check("sb_queue_drained", 32'(sb_q.size()), 32'd0);
`ifdef SCOREBOARD_STATS_EN
        check("stall_cycles_total", stall_cycles, 32'd4);
`else
        check("stall_cycles_tied", stall_cycles, 32'd0);
`endif

        // Watchdog: x10 held pending with a dependent instruction in ID.
        drive(nop, 1'b0, mk(LOAD, 10, 2, 0), 1'b1, 5'd0, 1'b0);
        @(posedge clk); #1;
        drive(dep10, 1'b1, nop, 1'b0, 5'd0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        check("wd_stall_14", {31'd0, stall}, 32'd1);
        check("wd_err_after_14", {31'd0, stall_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("wd_err_after_16", {31'd0, stall_err}, 32'd1);
        drive(dep10, 1'b1, nop, 1'b0, 5'd10, 1'b1);
        #1;
        check("wd_release_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        check("wd_err_sticky", {31'd0, stall_err}, 32'd1);
        check("wd_pending_clear", pending, 32'd0);

        // Reset in the middle of a stall.
        drive(nop, 1'b0, mk(LOAD, 10, 2, 0), 1'b1, 5'd0, 1'b0);
        @(posedge clk); #1;
        drive(dep10, 1'b1, nop, 1'b0, 5'd0, 1'b0);
        #1;
        check("rst_pre_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_forces_stall_low", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_stall_after", {31'd0, stall}, 32'd0);
        check("rst_pending_after", pending, 32'd0);
        check("rst_err_after", {31'd0, stall_err}, 32'd0);
        check("rst_stall_cycles_after", stall_cycles, 32'd0);
        @(posedge clk); #1;
        check("rst_no_stall_next", {31'd0, stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
